// File: rtl/boot_rom_loader_if.sv
// ----------------------------------------------------------------------------
// boot_rom_loader_if
// Purpose : bundles the boot-ROM read port and the instruction-RAM write port
//           used by boot_rom_loader.
// Signals :
//   rom_csn_o   ROM chip select, active-low
//   rom_a_o     ROM word address (ROM_AW bits)
//   rom_q_i     ROM read data, valid the cycle after the address is registered
//   mem_req_o   instruction-RAM write request
//   mem_gnt_i   grant; a write is accepted on an edge where req & gnt
//   mem_addr_o  byte address of the write
//   mem_wdata_o write data
//   mem_we_o    write enable (1 whenever mem_req_o)
//   mem_be_o    byte enables
// Modports: master = loader side, slave = ROM / memory-mux side.
// ----------------------------------------------------------------------------
interface boot_rom_loader_if #(
  parameter int ROM_AW = 10
);
  logic              rom_csn_o;
  logic [ROM_AW-1:0] rom_a_o;
  logic [31:0]       rom_q_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;

  modport master (
    output rom_csn_o, rom_a_o,
    input  rom_q_i,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_gnt_i
  );

  modport slave (
    input  rom_csn_o, rom_a_o,
    output rom_q_i,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_gnt_i
  );
endinterface

// File: rtl/boot_rom_loader.sv
// ----------------------------------------------------------------------------
// boot_rom_loader
// Purpose : at boot, copies NUM_WORDS 32-bit words from the boot ROM into
//           instruction RAM (word k -> byte address DST_BASE + 4*k). The core
//           is held off until done_o. Each word takes FETCH -> CAPT -> WRITE,
//           i.e. at least three cycles.
// Ports   :
//   CLK        clock
//   RSTN       asynchronous active-low reset
//   start_i    begin a copy; sampled only in IDLE or DONE
//   bus        boot_rom_loader_if.master (ROM read port + RAM write port)
//   busy_o     copy in progress
//   done_o     copy finished (level, cleared on restart)
//   chk_err_o  XOR-checksum mismatch against CHK_EXP
// Options : define BOOT_LOADER_CHK_EN to enable the XOR checksum of all copied
//           words; otherwise chk_err_o is tied 0 and CHK_EXP is unused.
// ----------------------------------------------------------------------------
module boot_rom_loader #(
  parameter int          ROM_AW    = 10,
  parameter int          NUM_WORDS = 548,
  parameter logic [31:0] DST_BASE  = 32'h0000_0000,
  parameter logic [31:0] CHK_EXP   = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                start_i,
  boot_rom_loader_if.master   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                chk_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ROM_AW:0] IDX_LAST = (ROM_AW+1)'(NUM_WORDS - 1);

  logic [2:0]        r_state;
  logic [ROM_AW:0]   r_idx;
  logic              r_rom_csn;
  logic [ROM_AW-1:0] r_rom_a;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_accept;
  logic              w_last;
  logic [ROM_AW:0]   w_idx_nxt;
  logic [31:0]       w_addr_nxt;

  // start is honoured only when not busy; a grant counts only while requesting
  assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i;
  assign w_accept   = (r_state == S_WRITE) && bus.mem_gnt_i;
  assign w_last     = (r_idx == IDX_LAST);
  assign w_idx_nxt  = r_idx + {{ROM_AW{1'b0}}, 1'b1};
  // 32-bit add; wraps modulo 2**32 if DST_BASE is near the top
  assign w_addr_nxt = DST_BASE + {{(29-ROM_AW){1'b0}}, w_idx_nxt, 2'b00};

  // Main copy FSM and all registered bus outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rom_csn   <= 1'b1;
      r_rom_a     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= DST_BASE;
      r_mem_wdata <= 32'h0000_0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_idx      <= '0;
            r_rom_csn  <= 1'b0;
            r_rom_a    <= '0;
            r_mem_addr <= DST_BASE;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= S_FETCH;
          end else begin
            r_state    <= r_state;
          end
        end
        S_FETCH: begin
          // ROM registers the address on this edge; release select so it
          // holds Q during CAPT and CSN is never low two cycles in a row
          r_rom_csn <= 1'b1;
          r_state   <= S_CAPT;
        end
        S_CAPT: begin
          r_mem_wdata <= bus.rom_q_i;
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          if (w_accept) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx      <= w_idx_nxt;
              r_rom_a    <= w_idx_nxt[ROM_AW-1:0];
              r_mem_addr <= w_addr_nxt;
              r_rom_csn  <= 1'b0;
              r_state    <= S_FETCH;
            end
          end else begin
            r_state <= S_WRITE;
          end
        end
        default: begin
          r_rom_csn <= 1'b1;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BOOT_LOADER_CHK_EN
  logic [31:0] r_chk;
  logic        r_chk_err;

  // XOR checksum of captured words; compared once on entry to DONE
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_chk     <= 32'h0000_0000;
      r_chk_err <= 1'b0;
    end else if (w_start) begin
      r_chk     <= 32'h0000_0000;
      r_chk_err <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_chk     <= r_chk ^ bus.rom_q_i;
    end else if (w_accept && w_last) begin
      r_chk_err <= (r_chk != CHK_EXP);
    end else begin
      r_chk     <= r_chk;
    end
  end

  assign chk_err_o = r_chk_err;
`else
  logic w_unused_chk_exp;
  assign w_unused_chk_exp = ^CHK_EXP;
  assign chk_err_o        = 1'b0;
`endif

  assign bus.rom_csn_o   = r_rom_csn;
  assign bus.rom_a_o     = r_rom_a;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_be_o    = 4'hF;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule

// File: tb/tb_boot_rom_loader.sv
// ----------------------------------------------------------------------------
// tb_boot_rom_loader
// Directed bench for boot_rom_loader with NUM_WORDS=4 and a small ROM model.
// ----------------------------------------------------------------------------
module tb_boot_rom_loader;

  localparam logic [31:0] CHK_GOOD = 32'h0100_007D; // 0x13^0x0100006F^0xA^0xB

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o, chk_err_o;
  logic gnt = 1'b1;

  boot_rom_loader_if #(.ROM_AW(10)) bus ();

  boot_rom_loader #(
    .ROM_AW(10), .NUM_WORDS(4), .DST_BASE(32'h0000_0000), .CHK_EXP(CHK_GOOD)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .chk_err_o(chk_err_o)
  );

  always #5 CLK = ~CLK;

  // ROM model: address registered when CSN low, Q held otherwise
  logic [31:0] rom_mem [0:15];
  logic [31:0] rom_q = 32'h0;
  always @(posedge CLK) if (!bus.rom_csn_o) rom_q <= rom_mem[bus.rom_a_o[3:0]];
  assign bus.rom_q_i   = rom_q;
  assign bus.mem_gnt_i = gnt;

  // Log accepted writes and ROM fetches; count back-to-back CSN low cycles
  logic [31:0] log_addr [0:15];
  logic [31:0] log_data [0:15];
  logic [31:0] fetch_a  [0:15];
  int log_n = 0, fetch_n = 0, csn_dbl = 0;
  logic prev_csn = 1'b1;
  always @(posedge CLK) begin
    if (bus.mem_req_o && gnt && log_n < 16) begin
      log_addr[log_n] = bus.mem_addr_o;
      log_data[log_n] = bus.mem_wdata_o;
      log_n++;
    end
    if (!bus.rom_csn_o && fetch_n < 16) begin
      fetch_a[fetch_n] = {22'h0, bus.rom_a_o};
      fetch_n++;
    end
    if (!bus.rom_csn_o && !prev_csn) csn_dbl++;
    prev_csn = bus.rom_csn_o;
  end

  int vectors = 0, fails = 0;
  logic [31:0] exp_data [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    start_i = 1'b1;
    @(posedge CLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK);
      #1;
      cyc++;
    end while (!done_o && cyc < 200);
  endtask

  task automatic wait_req_addr(input logic [31:0] a, output logic found);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      if (bus.mem_req_o && bus.mem_addr_o == a) found = 1'b1;
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, log_addr[i], 32'(i * 4));
      chk({tag, "_data"}, log_data[i], exp_data[i]);
    end
  endtask

  initial begin
    int cyc;
    logic found;
    logic exp_err;
    exp_data[0] = 32'h0000_0013; exp_data[1] = 32'h0100_006F;
    exp_data[2] = 32'h0000_000A; exp_data[3] = 32'h0000_000B;
    for (int i = 0; i < 16; i++) rom_mem[i] = 32'hDEAD_0000 + 32'(i);
    for (int i = 0; i < 4; i++) rom_mem[i] = exp_data[i];

    // 1: reset values
    repeat (3) @(negedge CLK);
    chk("rst_csn", bus.rom_csn_o, 32'd1);
    chk("rst_a", bus.rom_a_o, 32'd0);
    chk("rst_req", bus.mem_req_o, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_we", bus.mem_we_o, 32'd0);
    chk("rst_be", bus.mem_be_o, 32'hF);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_done", done_o, 32'd0);
    chk("rst_chkerr", chk_err_o, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_done", done_o, 32'd0);

    // 2: basic copy with gnt tied high
    log_n = 0; fetch_n = 0;
    start_pulse();
    chk("t2_busy", busy_o, 32'd1);
    chk("t2_csn_fetch", bus.rom_csn_o, 32'd0);
    wait_done(cyc);
    chk("t2_cycles", cyc, 32'd12);
    check_log("t2");
    chk("t2_fetch_n", fetch_n, 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_fetch_a", fetch_a[i], 32'(i));
    chk("t2_busy_end", busy_o, 32'd0);
    chk("t2_chkerr", chk_err_o, 32'd0);
    chk("t2_req_end", bus.mem_req_o, 32'd0);

    // 3+5: restart from DONE, withhold gnt on word 1, start_i pulsed while busy
    log_n = 0; fetch_n = 0;
    start_pulse();
    chk("t3_done_drop", done_o, 32'd0);
    chk("t3_busy", busy_o, 32'd1);
    wait_req_addr(32'h4, found);
    chk("t3_found", found, 32'd1);
    gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      start_i = (k == 1);
      chk("t3_hold_req", bus.mem_req_o, 32'd1);
      chk("t3_hold_addr", bus.mem_addr_o, 32'h4);
      chk("t3_hold_wdata", bus.mem_wdata_o, 32'h0100_006F);
      chk("t3_hold_csn", bus.rom_csn_o, 32'd1);
    end
    start_i = 1'b0;
    gnt = 1'b1;
    wait_done(cyc);
    chk("t3_done", done_o, 32'd1);
    check_log("t3");
    chk("t3_fetch_n", fetch_n, 32'd4);

    // 4: reset during WRITE of word 2, then full copy from word 0
    log_n = 0; fetch_n = 0;
    start_pulse();
    wait_req_addr(32'h8, found);
    chk("t4_found", found, 32'd1);
    RSTN = 1'b0;
    #1;
    chk("t4_req", bus.mem_req_o, 32'd0);
    chk("t4_csn", bus.rom_csn_o, 32'd1);
    chk("t4_addr", bus.mem_addr_o, 32'h0);
    chk("t4_wdata", bus.mem_wdata_o, 32'h0);
    chk("t4_we", bus.mem_we_o, 32'd0);
    chk("t4_busy", busy_o, 32'd0);
    chk("t4_done", done_o, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    chk("t4_partial", log_n, 32'd2);
    repeat (3) @(negedge CLK);
    chk("t4_no_resume", busy_o, 32'd0);
    log_n = 0;
    start_pulse();
    wait_done(cyc);
    chk("t4_cycles", cyc, 32'd12);
    check_log("t4");

    // 6: corrupt word 2 -> checksum error when enabled; clears on restart
`ifdef BOOT_LOADER_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rom_mem[2] = 32'h0000_00A5;
    log_n = 0;
    start_pulse();
    wait_done(cyc);
    chk("t6_data2", log_data[2], 32'h0000_00A5);
    chk("t6_chkerr", chk_err_o, 32'(exp_err));
    rom_mem[2] = 32'h0000_000A;
    start_pulse();
    chk("t6_clr", chk_err_o, 32'd0);
    wait_done(cyc);
    chk("t6_chkerr_ok", chk_err_o, 32'd0);

    chk("csn_double_low", csn_dbl, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
